// File: rtl/common_pkg.sv
// Shared widths plus register index and bit-position constants for the register bank.
// No logic; combinational constants only.
// No flow control.
package common_pkg;
    localparam int DATA_WIDTH     = 8;
    localparam int WB_ADDR_WIDTH  = 8;

    localparam int REG_IRQ_FLAG   = 0;
    localparam int REG_IRQ_ENABLE = 1;
    localparam int REG_CTRL       = 2;
    localparam int REG_SCRATCH    = 3;

    localparam int IRQ_FLAG_EVT0_BIT   = 0;
    localparam int IRQ_ENABLE_EVT0_BIT = 0;
    localparam int CTRL_STATUS_LSB     = 0;
    localparam int CTRL_STATUS_MSB     = 3;
    localparam int SCRATCH_LSB         = 0;
    localparam int SCRATCH_MSB         = DATA_WIDTH - 1;
endpackage

// File: rtl/wb_register_cell.sv
// One register: per-bit RW / read-only status / sticky write-1-to-clear muxing.
// Latency: 1 cycle from write, status or event to q.
// Backpressure: none, updates every cycle.
module wb_register_cell
    import common_pkg::*;
#(
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0,
    parameter logic [DATA_WIDTH-1:0] RO_MASK     = '0,
    parameter logic [DATA_WIDTH-1:0] W1C_MASK    = '0
) (
    input  logic                  wb_clock_i,
    input  logic                  wb_reset_ni,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [DATA_WIDTH-1:0] status,
    input  logic [DATA_WIDTH-1:0] event_pulse,
    output logic [DATA_WIDTH-1:0] q
);
    localparam logic [DATA_WIDTH-1:0] RW_MASK = ~(RO_MASK | W1C_MASK);

    logic [DATA_WIDTH-1:0] rw_next;
    logic [DATA_WIDTH-1:0] clr;
    logic [DATA_WIDTH-1:0] sticky_next;

    assign rw_next     = wr_en ? wr_data : q;
    assign clr         = wr_en ? wr_data : '0;
    // A new event wins over a clear landing in the same cycle.
    assign sticky_next = (q & ~clr) | event_pulse;

    always_ff @(posedge wb_clock_i) begin
        if (!wb_reset_ni) begin
            q <= RESET_VALUE & RW_MASK;
        end else begin
            q <= (rw_next & RW_MASK) | (status & RO_MASK) | (sticky_next & W1C_MASK);
        end
    end
endmodule

// File: rtl/wb_register_bank.sv
// Wishbone B4 pipelined register bank with RW/RO/W1C bits; IRQ output built only with REGBANK_IRQ_EN.
// Latency: ack and read data 1 cycle after accept; irq 1 cycle after flag/enable change.
// Backpressure: never stalls, one transfer accepted per cycle.
module wb_register_bank
    import common_pkg::*;
#(
    parameter int                                REG_COUNT      = 8,
    parameter logic [REG_COUNT*DATA_WIDTH-1:0]   RESET_VALUE    = '0,
    parameter logic [REG_COUNT*DATA_WIDTH-1:0]   RO_MASK        = '0,
    parameter logic [REG_COUNT*DATA_WIDTH-1:0]   W1C_MASK       = '0,
    parameter int                                IRQ_FLAG_REG   = REG_IRQ_FLAG,
    parameter int                                IRQ_ENABLE_REG = REG_IRQ_ENABLE
) (
    input  logic                              wb_clock_i,
    input  logic                              wb_reset_ni,
    input  logic [WB_ADDR_WIDTH-1:0]          wb_addr_i,
    input  logic [DATA_WIDTH-1:0]             wb_data_i,
    output logic [DATA_WIDTH-1:0]             wb_data_o,
    input  logic                              wb_we_i,
    input  logic                              wb_cycle_i,
    input  logic                              wb_strobe_i,
    input  logic                              wb_sel_i,
    output logic                              wb_stall_o,
    output logic                              wb_ack_o,
    input  logic [REG_COUNT*DATA_WIDTH-1:0]   status_i,
    input  logic [REG_COUNT*DATA_WIDTH-1:0]   event_i,
    output logic [REG_COUNT*DATA_WIDTH-1:0]   reg_o,
    output logic [REG_COUNT-1:0]              wr_pulse_o,
    output logic                              irq_o
);
    localparam int IDX_W = $clog2(REG_COUNT);

    logic [REG_COUNT-1:0][DATA_WIDTH-1:0] regs;
    logic [IDX_W-1:0]                     idx;
    logic                                 accept;
    logic                                 hit;
    logic [DATA_WIDTH-1:0]                rd_dat;
    logic [REG_COUNT-1:0]                 reg_sel;
    logic [REG_COUNT-1:0]                 wr_en;
    logic                                 unused_addr;

    assign accept      = wb_sel_i & wb_cycle_i & wb_strobe_i;
    assign idx         = wb_addr_i[IDX_W-1:0];
    assign unused_addr = ^wb_addr_i[WB_ADDR_WIDTH-1:IDX_W];
    assign wb_stall_o  = 1'b0;
    assign reg_o       = regs;

    // Indices past REG_COUNT match no register: they read 0 and drop writes.
    always_comb begin
        rd_dat  = '0;
        hit     = 1'b0;
        reg_sel = '0;
        for (int n = 0; n < REG_COUNT; n++) begin
            if (idx == IDX_W'(n)) begin
                rd_dat     = regs[n];
                hit        = 1'b1;
                reg_sel[n] = 1'b1;
            end
        end
    end

    assign wr_en = reg_sel & {REG_COUNT{accept & wb_we_i}};

    always_ff @(posedge wb_clock_i) begin
        if (!wb_reset_ni) begin
            wb_ack_o   <= 1'b0;
            wb_data_o  <= '0;
            wr_pulse_o <= '0;
        end else begin
            wb_ack_o   <= accept;
            wr_pulse_o <= wr_en;
            if (accept) begin
                wb_data_o <= hit ? rd_dat : '0;
            end
        end
    end

    for (genvar g = 0; g < REG_COUNT; g++) begin : g_cell
        wb_register_cell #(
            .RESET_VALUE (RESET_VALUE[g*DATA_WIDTH +: DATA_WIDTH]),
            .RO_MASK     (RO_MASK[g*DATA_WIDTH +: DATA_WIDTH]),
            .W1C_MASK    (W1C_MASK[g*DATA_WIDTH +: DATA_WIDTH])
        ) u_cell (
            .wb_clock_i  (wb_clock_i),
            .wb_reset_ni (wb_reset_ni),
            .wr_en       (wr_en[g]),
            .wr_data     (wb_data_i),
            .status      (status_i[g*DATA_WIDTH +: DATA_WIDTH]),
            .event_pulse (event_i[g*DATA_WIDTH +: DATA_WIDTH]),
            .q           (regs[g])
        );
    end

`ifdef REGBANK_IRQ_EN
    logic irq_q;

    always_ff @(posedge wb_clock_i) begin
        if (!wb_reset_ni) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= |(regs[IRQ_FLAG_REG] & regs[IRQ_ENABLE_REG]);
        end
    end

    assign irq_o = irq_q;
`else
    logic unused_irq_cfg;

    assign unused_irq_cfg = ^{IRQ_FLAG_REG, IRQ_ENABLE_REG};
    assign irq_o          = 1'b0;
`endif
endmodule
